// File: rtl/vec_reg_file.sv
// Vector operand register file: per-lane masked write port, two registered read ports
// with same-cycle write forwarding, and a one-cycle write acknowledge pulse.
module vec_reg_file #(
  parameter int WIDTH = 20,
  parameter int LANES = 8,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_en,
  input  logic [AW-1:0]                 rd_addr_a,
  input  logic [AW-1:0]                 rd_addr_b,
  output logic [LANES-1:0][WIDTH-1:0]   rd_data_a,
  output logic [LANES-1:0][WIDTH-1:0]   rd_data_b,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [LANES-1:0]              wr_lane_mask,
  input  logic [LANES-1:0][WIDTH-1:0]   wr_data,
  output logic                          wr_ack
);

  logic [LANES-1:0][WIDTH-1:0] regs [NREGS];
  logic [LANES-1:0][WIDTH-1:0] fwd_a;
  logic [LANES-1:0][WIDTH-1:0] fwd_b;

  // Storage kept in flops so the asynchronous reset can clear every word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_lane_mask[i]) begin
          regs[wr_addr][i] <= wr_data[i];
        end
      end
    end
  end

  // Per-lane bypass: only masked lanes of a matching write replace the stored word.
  always_comb begin
    fwd_a = regs[rd_addr_a];
    fwd_b = regs[rd_addr_b];
    for (int i = 0; i < LANES; i++) begin
      if (wr_en && wr_lane_mask[i] && (wr_addr == rd_addr_a)) begin
        fwd_a[i] = wr_data[i];
      end
      if (wr_en && wr_lane_mask[i] && (wr_addr == rd_addr_b)) begin
        fwd_b[i] = wr_data[i];
      end
    end
  end

  // Output stage: operands hold while rd_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      wr_ack    <= 1'b0;
    end else begin
      wr_ack <= wr_en;
      if (rd_en) begin
        rd_data_a <= fwd_a;
        rd_data_b <= fwd_b;
      end
    end
  end

endmodule

// File: tb/tb_vec_reg_file.sv
// Directed bench for vec_reg_file: reset clear, masked writes, forwarding, read hold, empty mask.
module tb_vec_reg_file;
  localparam int WIDTH = 20;
  localparam int LANES = 8;
  localparam int NREGS = 16;
  localparam int AW    = 4;

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            rd_en;
  logic [AW-1:0]   rd_addr_a;
  logic [AW-1:0]   rd_addr_b;
  vec_t            rd_data_a;
  vec_t            rd_data_b;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [LANES-1:0] wr_lane_mask;
  vec_t            wr_data;
  logic            wr_ack;

  int n_checks = 0;
  int n_fail   = 0;

  vec_reg_file #(.WIDTH(WIDTH), .LANES(LANES), .NREGS(NREGS)) dut (
    .clk          (clk),
    .reset        (reset),
    .rd_en        (rd_en),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_lane_mask (wr_lane_mask),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int l0, l1, l2, l3, l4, l5, l6, l7);
    vec_t v;
    v[0] = WIDTH'(l0); v[1] = WIDTH'(l1); v[2] = WIDTH'(l2); v[3] = WIDTH'(l3);
    v[4] = WIDTH'(l4); v[5] = WIDTH'(l5); v[6] = WIDTH'(l6); v[7] = WIDTH'(l7);
    return v;
  endfunction

  function automatic vec_t splat(input int x);
    return mk(x, x, x, x, x, x, x, x);
  endfunction

  task automatic idle();
    rd_en = 1'b0; wr_en = 1'b0; wr_lane_mask = '0; wr_data = '0;
    wr_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t expv;
    // outputs straight out of the initial reset
    n_checks++;
    if (rd_data_a !== '0 || rd_data_b !== '0 || wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: a=%h b=%h ack=%b expected all zero", rd_data_a, rd_data_b, wr_ack);
    end
    // populate some state so the later clear is observable
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_lane_mask = 8'hFF; wr_data = splat(11);
    @(negedge clk);
    wr_addr = 4'd6; wr_data = splat(22);
    @(negedge clk);
    wr_addr = 4'd9; wr_data = splat(44);
    rd_en = 1'b1; rd_addr_a = 4'd0; rd_addr_b = 4'd6;
    step();
    expv = splat(11);
    n_checks++;
    if (rd_data_a !== expv || rd_data_b !== splat(22) || wr_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL prereset_read: a=%h b=%h ack=%b expected a=%h b=%h ack=1", rd_data_a, rd_data_b, wr_ack, expv, splat(22));
    end
    // asynchronous assertion mid-cycle; a write held across reset edges is lost
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (rd_data_a !== '0 || rd_data_b !== '0 || wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: a=%h b=%h ack=%b expected all zero", rd_data_a, rd_data_b, wr_ack);
    end
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = splat(33);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    for (int a = 0; a < NREGS; a++) begin
      rd_en = 1'b1; rd_addr_a = AW'(a); rd_addr_b = AW'(NREGS - 1 - a);
      step();
      n_checks++;
      if (rd_data_a !== '0) begin
        n_fail++;
        $display("FAIL reset_sweep_a%0d: got %h expected 0", a, rd_data_a);
      end
      n_checks++;
      if (rd_data_b !== '0 || wr_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_sweep_b%0d: got %h ack=%b expected 0 ack=0", NREGS - 1 - a, rd_data_b, wr_ack);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_write_read();
    vec_t expv;
    expv = mk(200, 254, 251, 200, 5, 10, 100, 15);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd3; wr_lane_mask = 8'hFF; wr_data = expv;
    step();
    n_checks++;
    if (wr_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ack: got %b expected 1", wr_ack);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; rd_addr_a = 4'd3; rd_addr_b = 4'd4;
    step();
    n_checks++;
    if (rd_data_a !== expv || wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL write_read: a=%h ack=%b expected a=%h ack=0", rd_data_a, wr_ack, expv);
    end
    n_checks++;
    if (rd_data_b !== '0) begin
      n_fail++;
      $display("FAIL write_other_reg: b=%h expected 0", rd_data_b);
    end
    idle();
  endtask

  task automatic test_partial_mask();
    vec_t expv;
    expv = mk(7, 7, 7, 7, 5, 10, 100, 15);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd3; wr_lane_mask = 8'h0F; wr_data = splat(7);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; rd_addr_a = 4'd3;
    step();
    n_checks++;
    if (rd_data_a !== expv) begin
      n_fail++;
      $display("FAIL partial_mask: got %h expected %h", rd_data_a, expv);
    end
    idle();
  endtask

  task automatic test_forward();
    vec_t expv;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd5; wr_lane_mask = 8'hFF; wr_data = splat(300);
    rd_en = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd5;
    step();
    n_checks++;
    if (rd_data_a !== splat(300) || rd_data_b !== splat(300)) begin
      n_fail++;
      $display("FAIL forward_full: a=%h b=%h expected %h", rd_data_a, rd_data_b, splat(300));
    end
    // partial-mask write forwards only masked lanes; A on a different reg is independent
    @(negedge clk);
    wr_lane_mask = 8'hA5; wr_data = splat(1);
    rd_addr_a = 4'd3; rd_addr_b = 4'd5;
    step();
    expv = mk(1, 300, 1, 300, 300, 1, 300, 1);
    n_checks++;
    if (rd_data_b !== expv) begin
      n_fail++;
      $display("FAIL forward_partial: got %h expected %h", rd_data_b, expv);
    end
    n_checks++;
    if (rd_data_a !== mk(7, 7, 7, 7, 5, 10, 100, 15)) begin
      n_fail++;
      $display("FAIL forward_indep: got %h expected %h", rd_data_a, mk(7, 7, 7, 7, 5, 10, 100, 15));
    end
    idle();
  endtask

  task automatic test_read_hold();
    @(negedge clk);
    rd_en = 1'b1; rd_addr_b = 4'd2; rd_addr_a = 4'd3;
    step();
    n_checks++;
    if (rd_data_b !== '0) begin
      n_fail++;
      $display("FAIL hold_initial: got %h expected 0", rd_data_b);
    end
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd2; wr_lane_mask = 8'hFF; wr_data = splat(9);
    step();
    n_checks++;
    if (rd_data_b !== '0) begin
      n_fail++;
      $display("FAIL hold_during_write: got %h expected 0", rd_data_b);
    end
    @(negedge clk);
    wr_en = 1'b0;
    step();
    n_checks++;
    if (rd_data_b !== '0) begin
      n_fail++;
      $display("FAIL hold_after_write: got %h expected 0", rd_data_b);
    end
    @(negedge clk);
    rd_en = 1'b1;
    step();
    n_checks++;
    if (rd_data_b !== splat(9)) begin
      n_fail++;
      $display("FAIL hold_release: got %h expected %h", rd_data_b, splat(9));
    end
    idle();
  endtask

  task automatic test_empty_mask();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd1; wr_lane_mask = 8'h00;
    wr_data = mk(2, 6, 10, 15, 200, 8, 25, 50);
    rd_en = 1'b1; rd_addr_a = 4'd1; rd_addr_b = 4'd1;
    step();
    n_checks++;
    if (wr_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_mask_ack: got %b expected 1", wr_ack);
    end
    n_checks++;
    if (rd_data_a !== '0) begin
      n_fail++;
      $display("FAIL empty_mask_fwd: got %h expected 0", rd_data_a);
    end
    @(negedge clk);
    wr_en = 1'b0;
    step();
    n_checks++;
    if (rd_data_b !== '0 || wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_mask_store: b=%h ack=%b expected 0 ack=0", rd_data_b, wr_ack);
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #12;
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_partial_mask();
    test_forward();
    test_read_hold();
    test_empty_mask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
